// File: rtl/seg_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
// Holds the binary-to-BCD converter state enum, BCD/PWM widths and the
// digit-to-segment encoder ({A,B,C,D,E,F,G}, active-high).
package seg_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;
   localparam int unsigned PWM_W       = 4;
   localparam int unsigned SEG_W       = 7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } conv_state_e;

   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0000000;

   // Decimal digit to segment pattern; non-decimal codes light nothing.
   function automatic logic [SEG_W-1:0] seg_encode(input logic [BCD_DIGIT_W-1:0] d);
      logic [SEG_W-1:0] s;
      case (d)
         4'd0:    s = 7'b1111110;
         4'd1:    s = 7'b0110000;
         4'd2:    s = 7'b1101101;
         4'd3:    s = 7'b1111001;
         4'd4:    s = 7'b0110011;
         4'd5:    s = 7'b1011011;
         4'd6:    s = 7'b1011111;
         4'd7:    s = 7'b1110010;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1111011;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Signal bundle for one seg_scan_ctrl instance.
//   master: drives the value/blanking/brightness controls, observes the display.
//   slave : the display controller's view.
interface seg_scan_ctrl_if #(
   parameter int unsigned DIGITS = 8,
   parameter int unsigned BIN_W  = 32
);
   logic [BIN_W-1:0]  BINARY_SCORE;
   logic              BLANK_EN;
   logic [3:0]        BRIGHT;
   logic [DIGITS-1:0] Com;
   logic [6:0]        SEG;
   logic              BUSY;
   logic              OVF;

   modport master (
      output BINARY_SCORE, BLANK_EN, BRIGHT,
      input  Com, SEG, BUSY, OVF
   );

   modport slave (
      input  BINARY_SCORE, BLANK_EN, BRIGHT,
      output Com, SEG, BUSY, OVF
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
//   CLK, RST_N : clock, async active-low reset
//   value      : binary input, sampled when start is seen in IDLE
//   start      : request a conversion of value
//   busy       : high from the capture edge until the converter is back in IDLE
//   done       : one-cycle pulse after DONE; bcd/ovf are valid and stable then
//   bcd        : DIGITS packed BCD digits, digit 0 in bits [3:0]
//   ovf        : value needed more than DIGITS decimal digits
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int unsigned BIN_W  = 32,
   parameter int unsigned DIGITS = 8
) (
   input  logic                            CLK,
   input  logic                            RST_N,
   input  logic [BIN_W-1:0]                value,
   input  logic                            start,
   output logic                            busy,
   output logic                            done,
   output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd,
   output logic                            ovf
);

   localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   conv_state_e      state_q,   state_d;
   logic [BIN_W-1:0] shreg_q,   shreg_d;
   logic [BCD_W-1:0] work_q,    work_d;
   logic             ovf_tmp_q, ovf_tmp_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             busy_q,    busy_d;
   logic             done_q,    done_d;
   logic [BCD_W-1:0] adj_c;

   // +3 correction on every digit >= 5 ahead of the shift
   always_comb begin : add3
      adj_c = '0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if (work_q[4*i +: 4] >= 4'd5) adj_c[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
         else                          adj_c[4*i +: 4] = work_q[4*i +: 4];
      end
   end

   // Converter next state
   always_comb begin : next_c
      state_d   = state_q;
      shreg_d   = shreg_q;
      work_d    = work_q;
      ovf_tmp_d = ovf_tmp_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               shreg_d   = value;
               work_d    = '0;
               ovf_tmp_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_CONV;
            end
         end
         S_CONV: begin
            work_d  = {adj_c[BCD_W-2:0], shreg_q[BIN_W-1]};
            shreg_d = {shreg_q[BIN_W-2:0], 1'b0};
            // A carry out of the top digit means the value does not fit
            if (adj_c[BCD_W-1]) ovf_tmp_d = 1'b1;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BIN_W - 1)) state_d = S_DONE;
         end
         S_DONE: begin
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin : regs
      if (!RST_N) begin
         state_q   <= S_IDLE;
         shreg_q   <= '0;
         work_q    <= '0;
         ovf_tmp_q <= 1'b0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         work_q    <= work_d;
         ovf_tmp_q <= ovf_tmp_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = work_q;
   assign ovf  = ovf_tmp_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment display controller for an unsigned binary value.
//   CLK, RST_N   : clock, async active-low reset
//   BINARY_SCORE : value to show; a change triggers a fresh BCD conversion
//   BLANK_EN     : suppress leading zeros (digit 0 always lit)
//   BRIGHT       : PWM duty 0..15 within each digit slot, 15 = full
//   Com          : active-low digit enables, digit 0 on the top bit
//   SEG          : {A..G} active-high segments for the enabled digit
//   BUSY         : conversion in flight (capture through display update)
//   OVF          : value did not fit; all digits forced to 9
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned DIGITS     = 8,
   parameter int unsigned BIN_W      = 32,
   parameter int unsigned SCAN_SHIFT = 10
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [BIN_W-1:0]  BINARY_SCORE,
   input  logic              BLANK_EN,
   input  logic [3:0]        BRIGHT,
   output logic [DIGITS-1:0] Com,
   output logic [6:0]        SEG,
   output logic              BUSY,
   output logic              OVF
);

   localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned IDX_W = $clog2(DIGITS);

   logic [BIN_W-1:0]      last_q, last_d;
   logic [BCD_W-1:0]      disp_q, disp_d;
   logic                  ovf_q,  ovf_d;
   logic                  busy_q, busy_d;
   logic [SCAN_SHIFT-1:0] slot_q, slot_d;
   logic [IDX_W-1:0]      idx_q,  idx_d;
   logic [DIGITS-1:0]     com_q,  com_d;
   logic [SEG_W-1:0]      seg_q,  seg_d;

   logic                  start_c;
   logic                  conv_busy;
   logic                  conv_done;
   logic [BCD_W-1:0]      conv_bcd;
   logic                  conv_ovf;
   logic [3:0]            digit_c;
   logic                  blank_c;
   logic                  hi_zero_c;
   logic                  pwm_off_c;

   // New conversion only when fully idle, so only the latest value is taken
   assign start_c = (BINARY_SCORE != last_q) && !busy_q && !conv_busy;

   bin2bcd_seq #(
      .BIN_W  (BIN_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .CLK   (CLK),
      .RST_N (RST_N),
      .value (BINARY_SCORE),
      .start (start_c),
      .busy  (conv_busy),
      .done  (conv_done),
      .bcd   (conv_bcd),
      .ovf   (conv_ovf)
   );

   // Capture tracking and atomic display/OVF update
   always_comb begin : conv_next
      last_d = last_q;
      disp_d = disp_q;
      ovf_d  = ovf_q;
      busy_d = busy_q;
      if (start_c) begin
         last_d = BINARY_SCORE;
         busy_d = 1'b1;
      end else if (conv_done) begin
         disp_d = conv_bcd;
         ovf_d  = conv_ovf;
         busy_d = 1'b0;
      end
   end

   // Slot counter and digit index; index wraps at DIGITS-1
   always_comb begin : scan_next
      slot_d = slot_q + SCAN_SHIFT'(1);
      idx_d  = idx_q;
      if (slot_q == '1) begin
         if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
         else                             idx_d = idx_q + IDX_W'(1);
      end
   end

   // Active digit value and leading-zero blanking, scanning from the top digit
   always_comb begin : digit_sel
      digit_c   = 4'd0;
      blank_c   = 1'b0;
      hi_zero_c = 1'b1;
      for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
         hi_zero_c = hi_zero_c && (disp_q[4*i +: 4] == 4'd0);
         if (idx_q == IDX_W'(i)) begin
            digit_c = disp_q[4*i +: 4];
            blank_c = BLANK_EN && !ovf_q && (i != 0) && hi_zero_c;
         end
      end
   end

   assign pwm_off_c = (slot_q[SCAN_SHIFT-1 -: PWM_W] > BRIGHT);

   // Com and SEG registered together from the same slot/index
   always_comb begin : drive_next
      com_d = '1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         com_d[int'(DIGITS) - 1 - i] = !((idx_q == IDX_W'(i)) && !pwm_off_c);
      end
      if (blank_c)    seg_d = SEG_BLANK;
      else if (ovf_q) seg_d = seg_encode(4'd9);
      else            seg_d = seg_encode(digit_c);
   end

   always_ff @(posedge CLK or negedge RST_N) begin : regs
      if (!RST_N) begin
         last_q <= '0;
         disp_q <= '0;
         ovf_q  <= 1'b0;
         busy_q <= 1'b0;
         slot_q <= '0;
         idx_q  <= '0;
         com_q  <= '1;
         seg_q  <= '0;
      end else begin
         last_q <= last_d;
         disp_q <= disp_d;
         ovf_q  <= ovf_d;
         busy_q <= busy_d;
         slot_q <= slot_d;
         idx_q  <= idx_d;
         com_q  <= com_d;
         seg_q  <= seg_d;
      end
   end

   assign Com  = com_q;
   assign SEG  = seg_q;
   assign BUSY = busy_q;
   assign OVF  = ovf_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: three instances with different
// DIGITS/BIN_W and a short scan slot so whole frames fit in a few hundred cycles.
module tb_seg_scan_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   localparam logic [6:0] ENC [10] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110010, 7'b1111111, 7'b1111011
   };

   logic [6:0] seen [8];
   logic [6:0] log_q [$];

   always #5 clk = ~clk;

   seg_scan_ctrl_if #(.DIGITS(8), .BIN_W(32)) if_a ();
   seg_scan_ctrl_if #(.DIGITS(4), .BIN_W(16)) if_b ();
   seg_scan_ctrl_if #(.DIGITS(5), .BIN_W(16)) if_c ();

   seg_scan_ctrl #(.DIGITS(8), .BIN_W(32), .SCAN_SHIFT(5)) dut_a (
      .CLK(clk), .RST_N(rst_n), .BINARY_SCORE(if_a.BINARY_SCORE), .BLANK_EN(if_a.BLANK_EN),
      .BRIGHT(if_a.BRIGHT), .Com(if_a.Com), .SEG(if_a.SEG), .BUSY(if_a.BUSY), .OVF(if_a.OVF));

   seg_scan_ctrl #(.DIGITS(4), .BIN_W(16), .SCAN_SHIFT(5)) dut_b (
      .CLK(clk), .RST_N(rst_n), .BINARY_SCORE(if_b.BINARY_SCORE), .BLANK_EN(if_b.BLANK_EN),
      .BRIGHT(if_b.BRIGHT), .Com(if_b.Com), .SEG(if_b.SEG), .BUSY(if_b.BUSY), .OVF(if_b.OVF));

   seg_scan_ctrl #(.DIGITS(5), .BIN_W(16), .SCAN_SHIFT(5)) dut_c (
      .CLK(clk), .RST_N(rst_n), .BINARY_SCORE(if_c.BINARY_SCORE), .BLANK_EN(if_c.BLANK_EN),
      .BRIGHT(if_c.BRIGHT), .Com(if_c.Com), .SEG(if_c.SEG), .BUSY(if_c.BUSY), .OVF(if_c.OVF));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return if_a.BUSY;
         1:       return if_b.BUSY;
         default: return if_c.BUSY;
      endcase
   endfunction

   task automatic wait_busy(input int sel, input logic lvl, input string tag);
      int n;
      n = 0;
      while (busy_of(sel) !== lvl && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(busy_of(sel)), 32'(lvl));
   endtask

   // Records the SEG pattern seen while each digit is enabled over one frame
   task automatic scan_frame(input int sel);
      logic [7:0] com;
      logic [6:0] seg;
      int nd;
      for (int k = 0; k < 8; k++) seen[k] = 7'bx;
      nd = (sel == 0) ? 8 : 4;
      for (int c = 0; c < nd * 32 + 40; c++) begin
         @(negedge clk);
         if (sel == 0) begin
            com = if_a.Com;
            seg = if_a.SEG;
         end else begin
            com = {4'hF, if_b.Com};
            seg = if_b.SEG;
         end
         for (int k = 0; k < nd; k++) if (com[nd-1-k] == 1'b0) seen[k] = seg;
      end
   endtask

   initial begin
      int nb;
      int n;
      int act;
      logic [6:0] lg0;
      logic [6:0] lg1;
      logic [4:0] one5;
      logic [4:0] exp5;

      if_a.BINARY_SCORE = 32'd1234; if_a.BLANK_EN = 1'b1; if_a.BRIGHT = 4'd15;
      if_b.BINARY_SCORE = 16'd0;    if_b.BLANK_EN = 1'b1; if_b.BRIGHT = 4'd15;
      if_c.BINARY_SCORE = 16'd0;    if_c.BLANK_EN = 1'b1; if_c.BRIGHT = 4'd3;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_com",  32'(if_a.Com),  32'hFF);
      chk("rst_seg",  32'(if_a.SEG),  32'h0);
      chk("rst_busy", 32'(if_a.BUSY), 32'h0);
      chk("rst_ovf",  32'(if_a.OVF),  32'h0);

      // 1234 with blanking: BUSY length then digits
      rst_n = 1'b1;
      nb = 0;
      repeat (100) begin
         @(negedge clk);
         if (if_a.BUSY === 1'b1) nb++;
      end
      chk("busy_len_1234", nb, 34);
      chk("ovf_1234", 32'(if_a.OVF), 32'h0);
      scan_frame(0);
      chk("d0_1234", 32'(seen[0]), 32'(ENC[4]));
      chk("d1_1234", 32'(seen[1]), 32'(ENC[3]));
      chk("d2_1234", 32'(seen[2]), 32'(ENC[2]));
      chk("d3_1234", 32'(seen[3]), 32'(ENC[1]));
      for (int k = 4; k < 8; k++) chk($sformatf("blank%0d_1234", k), 32'(seen[k]), 32'h0);

      // Zero: only digit 0 lit
      if_a.BINARY_SCORE = 32'd0;
      wait_busy(0, 1'b1, "busy_rise_0");
      wait_busy(0, 1'b0, "busy_fall_0");
      scan_frame(0);
      chk("d0_zero", 32'(seen[0]), 32'(ENC[0]));
      for (int k = 1; k < 8; k++) chk($sformatf("blank%0d_zero", k), 32'(seen[k]), 32'h0);

      // 5 then 77 mid-conversion, observed through one digit-0 window
      n = 0;
      while (if_a.Com === 8'h7F && n < 300) begin @(negedge clk); n++; end
      n = 0;
      while (if_a.Com !== 8'h7F && n < 300) begin @(negedge clk); n++; end
      chk("d0_window_a", 32'(if_a.Com), 32'h7F);
      repeat (200) @(negedge clk);
      if_a.BINARY_SCORE = 32'd5;
      wait_busy(0, 1'b1, "busy_rise_5");
      repeat (10) @(negedge clk);
      if_a.BINARY_SCORE = 32'd77;
      n = 0;
      while (if_a.Com !== 8'h7F && n < 300) begin @(negedge clk); n++; end
      chk("d0_window_b", 32'(if_a.Com), 32'h7F);
      log_q.delete();
      repeat (32) begin
         if (if_a.Com === 8'h7F && (log_q.size() == 0 || log_q[$] !== if_a.SEG))
            log_q.push_back(if_a.SEG);
         @(negedge clk);
      end
      lg0 = (log_q.size() > 0) ? log_q[0] : 7'bx;
      lg1 = (log_q.size() > 1) ? log_q[1] : 7'bx;
      chk("seq_len",   log_q.size(), 2);
      chk("seq_first", 32'(lg0), 32'(ENC[5]));
      chk("seq_second", 32'(lg1), 32'(ENC[7]));
      wait_busy(0, 1'b0, "busy_fall_77");
      scan_frame(0);
      chk("d0_77", 32'(seen[0]), 32'(ENC[7]));
      chk("d1_77", 32'(seen[1]), 32'(ENC[7]));
      chk("d2_77", 32'(seen[2]), 32'h0);

      // Reset mid-conversion
      if_a.BINARY_SCORE = 32'd4321;
      wait_busy(0, 1'b1, "busy_rise_4321");
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_com",  32'(if_a.Com),  32'hFF);
      chk("abort_seg",  32'(if_a.SEG),  32'h0);
      chk("abort_busy", 32'(if_a.BUSY), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_com",  32'(if_a.Com),  32'h7F);
      chk("post_rst_seg",  32'(if_a.SEG),  32'(ENC[0]));
      chk("post_rst_busy", 32'(if_a.BUSY), 32'h1);
      repeat (25) @(negedge clk);
      chk("late_seg", 32'(if_a.SEG), 32'(ENC[0]));
      wait_busy(0, 1'b0, "busy_fall_4321");
      scan_frame(0);
      chk("d0_4321", 32'(seen[0]), 32'(ENC[1]));
      chk("d1_4321", 32'(seen[1]), 32'(ENC[2]));
      chk("d2_4321", 32'(seen[2]), 32'(ENC[3]));
      chk("d3_4321", 32'(seen[3]), 32'(ENC[4]));
      chk("d4_4321", 32'(seen[4]), 32'h0);

      // Four-digit overflow and its boundary
      if_b.BINARY_SCORE = 16'd12345;
      wait_busy(1, 1'b1, "busy_rise_12345");
      wait_busy(1, 1'b0, "busy_fall_12345");
      chk("ovf_12345", 32'(if_b.OVF), 32'h1);
      scan_frame(1);
      for (int k = 0; k < 4; k++) chk($sformatf("d%0d_12345", k), 32'(seen[k]), 32'(ENC[9]));
      if_b.BINARY_SCORE = 16'd9999;
      wait_busy(1, 1'b1, "busy_rise_9999");
      wait_busy(1, 1'b0, "busy_fall_9999");
      chk("ovf_9999", 32'(if_b.OVF), 32'h0);
      scan_frame(1);
      for (int k = 0; k < 4; k++) chk($sformatf("d%0d_9999", k), 32'(seen[k]), 32'(ENC[9]));

      // PWM duty and five-digit index wrap
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (if_c.Com === 5'h1F && n < 10) begin @(negedge clk); n++; end
      one5 = 5'd1;
      for (int k = 0; k < 6; k++) begin
         exp5 = ~(one5 << (4 - (k % 5)));
         chk($sformatf("slot%0d_com", k), 32'(if_c.Com), 32'(exp5));
         act = 0;
         repeat (32) begin
            if (if_c.Com !== 5'h1F) act++;
            @(negedge clk);
         end
         chk($sformatf("slot%0d_duty", k), act, 8);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGITS, default 8: number of 7-segment digits driven (2..8).
REQ-002 SHALL have parameter BIN_W, default 32: width of the binary input value.
REQ-003 SHALL have parameter SCAN_SHIFT, default 10: log2 of clocks per digit slot (≥5).
REQ-004 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port BINARY_SCORE  input  BIN_W  unsigned value to display.
REQ-007 SHALL have port BLANK_EN  input  1  1 = leading-zero blanking on.
REQ-008 SHALL have port BRIGHT  input  4  brightness level 0..15.
REQ-009 SHALL have port Com  output  DIGITS  active-low digit enables, registered.
REQ-010 SHALL have port SEG  output  7  segments {A,B,C,D,E,F,G}, active-high, registered.
REQ-011 SHALL have port BUSY  output  1  high while a conversion is running.
REQ-012 SHALL have port OVF  output  1  high when the displayed value exceeded DIGITS decimal digits.

Function
REQ-013 Converter states SHALL be IDLE, CONV, DONE; reset state IDLE.
REQ-014 IDLE: if BINARY_SCORE differs from last captured value, SHALL capture it, clear the BCD register and OVF_tmp, and go to CONV.
REQ-015 CONV SHALL run sequential double-dabble with DIGITS BCD digits, one input bit per cycle, MSB first, for exactly BIN_W cycles.
REQ-016 Each CONV cycle: any BCD digit ≥5 SHALL get +3 before the shift; a 1 shifted out of the top digit SHALL set OVF_tmp.
REQ-017 DONE (one cycle) SHALL copy the BCD register to the display register and OVF_tmp to OVF atomically, then return to IDLE.
REQ-018 Latency SHALL be BIN_W+2 cycles from the capture edge to the display register update; BUSY SHALL be high in CONV and DONE.
REQ-019 When OVF is set, every digit SHALL display 9 regardless of BCD contents.
REQ-020 Input changes during CONV/DONE SHALL be ignored; IDLE SHALL re-evaluate on the next cycle, converting only the latest value.
REQ-021 Slot counter (SCAN_SHIFT bits) SHALL increment every cycle; on wrap the digit index SHALL advance 0..DIGITS-1 and wrap to 0 (non-power-of-2 DIGITS supported).
REQ-022 Com[DIGITS-1-idx] SHALL be 0 for the active digit idx and all other bits 1 (digit 0 = least significant, on the highest Com bit).
REQ-023 PWM: Com SHALL be all 1s whenever slot_cnt[SCAN_SHIFT-1:SCAN_SHIFT-4] > BRIGHT; BRIGHT=15 gives full duty.
REQ-024 Blanking: with BLANK_EN=1, digit idx>0 SHALL show SEG=0 if it and all higher digits are 0; digit 0 SHALL never be blanked; OVF disables blanking.
REQ-025 Encoding SHALL be 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110010, 8=1111111, 9=1111011; other codes SHALL give 0000000.
REQ-026 Com and SEG SHALL be registered together from the same idx, with one cycle latency from the counter state.

Reset
REQ-027 While RST_N=0: Com all 1s, SEG=0, BUSY=0, OVF=0, counters, idx, BCD and display registers 0, captured value 0, state IDLE.
REQ-028 Reset SHALL abort a conversion mid-flight with no partial display update; after release, a nonzero input SHALL start a fresh conversion.

Structure
REQ-029 Package seg_pkg SHALL hold the converter state enum and the 7-segment digit encoding function/constants.
REQ-030 The converter SHALL be sub-module bin2bcd_seq (params BIN_W, DIGITS; ports CLK, RST_N, value, start, busy, done, bcd, ovf); scan/PWM/blanking stay in seg_scan_ctrl.

Verification
REQ-031 Reset, then BINARY_SCORE=1234, BLANK_EN=1, BRIGHT=15 -> BUSY high 34 cycles; then digits 0..3 show 4,3,2,1, digits 4..7 SEG=0.
REQ-032 BINARY_SCORE=0, BLANK_EN=1 -> digit 0 shows 1111110; all other digits SEG=0.
REQ-033 DIGITS=4, BINARY_SCORE=12345 -> OVF=1, all four digits show 9; then 9999 -> OVF=0, shows 9999.
REQ-034 Change value 5->77 on CONV cycle 10 -> display shows 5 first, then 77 after a second conversion; no intermediate value.
REQ-035 BRIGHT=3, SCAN_SHIFT=5 -> in each 32-cycle slot Com active exactly 8 cycles; DIGITS=5 -> idx sequence 0..4,0 and Com bit 4 active for idx 0.
REQ-036 RST_N pulsed low during CONV -> Com=all 1s, SEG=0 immediately (async); display 0 until the next full conversion.
